// File: rtl/gerador_aleatorio_param.sv
// Parameterised Fibonacci LFSR with a ranged-draw front end (result in 0..max_val).
// Define GERADOR_ALEATORIO_REJECT_EN for rejection sampling; otherwise a one-cycle fold-back draw is used.
module gerador_aleatorio_param #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] SEED      = 32'h13,
  parameter int unsigned OUT_BITS  = 8,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic                req,
  input  logic [OUT_BITS-1:0] max_val,
  output logic [WIDTH-1:0]    data,
  output logic                busy,
  output logic                rnd_valid,
  output logic [OUT_BITS-1:0] rnd_out
);

  // An all-zero seed would lock the register up, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_TRUNC = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF   = (SEED_TRUNC == '0) ? WIDTH'(1) : SEED_TRUNC;

  localparam logic [31:0] TAPS32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                   (WIDTH == 16) ? 32'h0000_D008 :
                                   (WIDTH == 24) ? 32'h00E1_0000 :
                                                   32'h8020_0003;
  localparam logic [WIDTH-1:0]    TAPS = TAPS32[WIDTH-1:0];
  localparam logic [OUT_BITS-1:0] ONE  = OUT_BITS'(1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [OUT_BITS-1:0] max_q, max_d;
  logic [OUT_BITS-1:0] rnd_out_q, rnd_out_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic [OUT_BITS-1:0] mask, cand, wrapped;
  logic                in_range, fb;
`ifdef GERADOR_ALEATORIO_REJECT_EN
  localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);
  logic [7:0]          tries_q, tries_d;
`endif

  // Smear the highest set bit downwards: smallest 2^k-1 covering v.
  function automatic logic [OUT_BITS-1:0] fill_mask(input logic [OUT_BITS-1:0] v);
    logic [OUT_BITS-1:0] m;
    m = v;
    for (int i = 1; i < OUT_BITS; i++) m = m | (v >> i);
    return m;
  endfunction

  assign fb       = ^(data_q & TAPS);
  assign mask     = fill_mask(max_q);
  assign cand     = data_q[OUT_BITS-1:0] & mask;
  assign in_range = (cand <= max_q);
  assign wrapped  = cand - max_q - ONE;

  assign data      = data_q;
  assign busy      = (state_q == DRAW);
  assign rnd_valid = rnd_valid_q;
  assign rnd_out   = rnd_out_q;

  always_comb begin
    data_d = data_q;
    if (seed_load)          data_d = (seed_in == '0) ? SEED_EFF : seed_in;
    else if (data_q == '0)  data_d = SEED_EFF;
    else if (en || busy)    data_d = {data_q[WIDTH-2:0], fb};
  end

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    rnd_out_d   = rnd_out_q;
    rnd_valid_d = 1'b0;
`ifdef GERADOR_ALEATORIO_REJECT_EN
    tries_d     = tries_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          max_d   = max_val;
          state_d = DRAW;
`ifdef GERADOR_ALEATORIO_REJECT_EN
          tries_d = '0;
`endif
        end
      end
      DRAW: begin
`ifdef GERADOR_ALEATORIO_REJECT_EN
        if (in_range) begin
          rnd_out_d   = cand;
          rnd_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (tries_q == TRY_LAST) begin
          rnd_out_d   = wrapped;
          rnd_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tries_d = tries_q + 8'd1;
        end
`else
        rnd_out_d   = in_range ? cand : wrapped;
        rnd_valid_d = 1'b1;
        state_d     = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= SEED_EFF;
      state_q     <= IDLE;
      max_q       <= '0;
      rnd_out_q   <= '0;
      rnd_valid_q <= 1'b0;
`ifdef GERADOR_ALEATORIO_REJECT_EN
      tries_q     <= '0;
`endif
    end else begin
      data_q      <= data_d;
      state_q     <= state_d;
      max_q       <= max_d;
      rnd_out_q   <= rnd_out_d;
      rnd_valid_q <= rnd_valid_d;
`ifdef GERADOR_ALEATORIO_REJECT_EN
      tries_q     <= tries_d;
`endif
    end
  end

endmodule
